// File: rtl/fixed_to_fp32.sv
// Three-stage signed fixed-point to FP32 converter (capture, normalise, pack).
// Define FIXED_TO_FP32_RNE_EN for round-to-nearest-even; otherwise discarded bits are truncated.
module fixed_to_fp32 #(
  parameter int IN_W      = 24,
  parameter int FRAC_BITS = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   busy
);

  localparam int P_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int EW  = IN_W + 24;

  function automatic logic [P_W-1:0] lead_one(input logic [IN_W-1:0] v);
    lead_one = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (v[i]) lead_one = P_W'(i);
    end
  endfunction

  function automatic logic [31:0] pack_fp(input logic       s,
                                          input logic [7:0] e,
                                          input logic [22:0] f
`ifdef FIXED_TO_FP32_RNE_EN
                                          , input logic      g,
                                          input logic        st
`endif
                                          );
`ifdef FIXED_TO_FP32_RNE_EN
    logic [23:0] fr;
    logic [7:0]  er;
    fr = {1'b0, f} + 24'(g & (st | f[0]));
    // A carry out of the fraction leaves fr[22:0] all zero and bumps the exponent.
    er = e + 8'(fr[23]);
    pack_fp = {s, er, fr[22:0]};
`else
    pack_fp = {s, e, f};
`endif
  endfunction

  logic            adv;
  logic            vld_p1, vld_p2, vld_p3;
  logic            sign_p1, zero_p1;
  logic [IN_W-1:0] mag_p1;
  logic            sign_p2, zero_p2;
  logic [IN_W-1:0] norm_p2;
  logic [7:0]      exp_p2;
  logic [31:0]     data_p3;

  assign adv       = ~vld_p3 | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p3;
  assign out_data  = data_p3;
  assign busy      = vld_p1 | vld_p2 | vld_p3;

  // Stage 1: sign and magnitude; the most negative input maps to 2^(IN_W-1).
  logic            sign_c;
  logic [IN_W-1:0] mag_c;
  assign sign_c = in_data[IN_W-1];
  assign mag_c  = sign_c ? $unsigned(-in_data) : $unsigned(in_data);

  // Stage 2: leading-one detect and left-justify.
  logic [P_W-1:0]  p_c;
  logic [IN_W-1:0] norm_c;
  logic [7:0]      exp_c;
  assign p_c    = lead_one(mag_p1);
  assign norm_c = mag_p1 << (P_W'(IN_W - 1) - p_c);
  assign exp_c  = 8'(127 + int'(p_c) - FRAC_BITS);

  // Stage 3: extract the 23 fraction bits under the implicit one, then round.
  logic [EW-1:0] ext_c;
  logic [22:0]   frac_c;
  logic [31:0]   fp_c;
  assign ext_c  = {norm_p2, 24'd0};
  assign frac_c = ext_c[EW-2 -: 23];

`ifdef FIXED_TO_FP32_RNE_EN
  logic guard_c, sticky_c, unused_lead;
  assign guard_c     = ext_c[IN_W-1];
  assign sticky_c    = |ext_c[IN_W-2:0];
  assign unused_lead = ext_c[EW-1];
  assign fp_c        = pack_fp(sign_p2, exp_p2, frac_c, guard_c, sticky_c);
`else
  logic unused_bits;
  assign unused_bits = ^{ext_c[EW-1], ext_c[IN_W-1:0]};
  assign fp_c        = pack_fp(sign_p2, exp_p2, frac_c);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      data_p3 <= 32'd0;
    end else if (adv) begin
      vld_p1  <= in_valid;
      vld_p2  <= vld_p1;
      vld_p3  <= vld_p2;
      data_p3 <= zero_p2 ? 32'd0 : fp_c;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1 <= sign_c;
      mag_p1  <= mag_c;
      zero_p1 <= (mag_c == '0);
      sign_p2 <= sign_p1;
      zero_p2 <= zero_p1;
      norm_p2 <= norm_c;
      exp_p2  <= exp_c;
    end
  end

endmodule

// File: tb/tb_fixed_to_fp32.sv
// Directed bench for fixed_to_fp32: three instances (24/0, 24/8, 32/0) share clock and handshakes.
module tb_fixed_to_fp32;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, out_ready;
  logic signed [23:0] d_a, d_b;
  logic signed [31:0] d_c;
  logic               rdy_a, rdy_b, rdy_c;
  logic               ov_a, ov_b, ov_c;
  logic [31:0]        od_a, od_b, od_c;
  logic               busy_a, busy_b, busy_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fixed_to_fp32 #(.IN_W(24), .FRAC_BITS(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_data(d_a),
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .busy(busy_a));
  fixed_to_fp32 #(.IN_W(24), .FRAC_BITS(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b), .in_data(d_b),
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .busy(busy_b));
  fixed_to_fp32 #(.IN_W(32), .FRAC_BITS(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_data(d_c),
    .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample to every instance; returns when the result is visible.
  task automatic send1(input logic [23:0] a, input logic [23:0] b, input logic [31:0] c);
    in_valid = 1'b1;
    d_a = a;
    d_b = b;
    d_c = c;
    tick();
    in_valid = 1'b0;
    tick();
    chk("lat_early", 32'(ov_a), 32'd0);
    tick();
    chk("lat_valid", 32'(ov_a), 32'd1);
  endtask

  logic [23:0] t5_in  [8];
  logic [31:0] t5_exp [8];
  int          iidx, oidx, nstall;
  logic        stalled;
  logic [31:0] held;
  logic [31:0] exp_t4a, exp_t4b;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FIXED_TO_FP32_RNE_EN
    exp_t4a = 32'h4B800002;
    exp_t4b = 32'h4F000000;
`else
    exp_t4a = 32'h4B800001;
    exp_t4b = 32'h4EFFFFFF;
`endif
    t5_in[0] = 24'h000001; t5_exp[0] = 32'h3F800000;
    t5_in[1] = 24'h000002; t5_exp[1] = 32'h40000000;
    t5_in[2] = 24'h000003; t5_exp[2] = 32'h40400000;
    t5_in[3] = 24'hFFFFFE; t5_exp[3] = 32'hC0000000;
    t5_in[4] = 24'h000004; t5_exp[4] = 32'h40800000;
    t5_in[5] = 24'h000005; t5_exp[5] = 32'h40A00000;
    t5_in[6] = 24'hFFFFFD; t5_exp[6] = 32'hC0400000;
    t5_in[7] = 24'h000008; t5_exp[7] = 32'h41000000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    d_a = '0;
    d_b = '0;
    d_c = '0;
    repeat (2) tick();
    chk("rst_out_valid", 32'(ov_a), 32'd0);
    chk("rst_busy", 32'(busy_a | busy_b | busy_c), 32'd0);
    chk("rst_out_data", od_a, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(rdy_a), 32'd1);
    tick();

    // T1: 1, -1, 0 back to back
    in_valid = 1'b1; d_a = 24'h000001;
    tick();
    d_a = 24'hFFFFFF;
    tick();
    d_a = 24'h000000;
    tick();
    in_valid = 1'b0;
    chk("t1_v0", 32'(ov_a), 32'd1);
    chk("t1_one", od_a, 32'h3F800000);
    tick();
    chk("t1_v1", 32'(ov_a), 32'd1);
    chk("t1_minus_one", od_a, 32'hBF800000);
    tick();
    chk("t1_v2", 32'(ov_a), 32'd1);
    chk("t1_zero", od_a, 32'h00000000);
    tick();
    chk("t1_drain_valid", 32'(ov_a), 32'd0);
    chk("t1_drain_busy", 32'(busy_a), 32'd0);

    // T2/T3/T4 in parallel on the three instances
    send1(24'h800000, 24'h000180, 32'h01000003);
    chk("t2_most_neg", od_a, 32'hCB000000);
    chk("t3_1p5", od_b, 32'h3FC00000);
    chk("t4_round_a", od_c, exp_t4a);
    send1(24'h7FFFFF, 24'hFFFF80, 32'h7FFFFFFF);
    chk("t2_most_pos", od_a, 32'h4AFFFFFE);
    chk("t3_minus_half", od_b, 32'hBF000000);
    chk("t4_round_b", od_c, exp_t4b);
    send1(24'h400000, 24'h000001, 32'h80000000);
    chk("pow2_22", od_a, 32'h4A800000);
    chk("frac_lsb", od_b, 32'h3B800000);
    chk("w32_most_neg", od_c, 32'hCF000000);
    tick();

    // T5: 8-sample stream with a 5-cycle downstream stall
    iidx = 0; oidx = 0; nstall = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 60 && oidx < 8; c++) begin
      out_ready = !(c >= 6 && c < 11);
      in_valid  = (iidx < 8);
      d_a       = (iidx < 8) ? t5_in[iidx] : 24'd0;
      #1;
      if (ov_a && !out_ready) begin
        chk("t5_stall_in_ready", 32'(rdy_a), 32'd0);
        if (stalled) chk("t5_stall_hold", od_a, held);
        held    = od_a;
        stalled = 1'b1;
        nstall++;
      end else begin
        stalled = 1'b0;
      end
      if (ov_a && out_ready) begin
        chk("t5_data", od_a, t5_exp[oidx]);
        oidx++;
      end
      if (in_valid && rdy_a) iidx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_out_count", 32'(oidx), 32'd8);
    chk("t5_in_count", 32'(iidx), 32'd8);
    chk("t5_stall_seen", 32'(nstall), 32'd5);
    repeat (3) tick();
    chk("t5_idle", 32'(busy_a), 32'd0);

    // T6: async reset with three samples in flight
    in_valid = 1'b1;
    d_a = 24'h000001;
    tick();
    d_a = 24'h000002;
    tick();
    d_a = 24'h000003;
    tick();
    in_valid = 1'b0;
    chk("t6_inflight", 32'(ov_a & busy_a), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(ov_a), 32'd0);
    chk("t6_rst_busy", 32'(busy_a), 32'd0);
    chk("t6_rst_data", od_a, 32'd0);
    #1 rst = 1'b0;
    #1;
    chk("t6_in_ready", 32'(rdy_a), 32'd1);
    tick();
    send1(24'h000007, 24'h000000, 32'h00000000);
    chk("t6_after_rst", od_a, 32'h40E00000);
    chk("t6_zero_b", od_b, 32'h00000000);
    tick();
    chk("t6_single", 32'(ov_a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
